rst_sequencer: RTL

//  Parametrised reset sequencer for multi-DCM designs. Qualifies N_LOCK asynchronous

---
 rtl/rst_sequencer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/rst_sequencer.sv
// Reset sequencer for multi-clock-generator designs.
// It synchronises the LOCKED inputs and holds all domains in reset until lock
// has been stable. It then releases the active-low domain resets one after
// another, and restarts the whole sequence on lock loss or a soft-reset request.
//
//   state     | meaning
//   WAIT_LOCK | all domains in reset, waiting for qualified lock
//   HOLD      | lock seen, counting HOLD_CYCLES before releasing channel 0
//   RELEASE   | releasing channels 1..N_CH-1, STAGE_GAP cycles apart
//   RUN       | all channels released, READY high
module rst_sequencer #(
  parameter int N_CH        = 4,
  parameter int N_LOCK      = 2,
  parameter int HOLD_CYCLES = 128,
  parameter int STAGE_GAP   = 16,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N_LOCK-1:0] i_locked,
  input  logic              i_srst_req,
  output logic [N_CH-1:0]   o_rst_x,
  output logic              o_ready,
  output logic [CNT_W-1:0]  o_loss_cnt,
  output logic [1:0]        o_state
);

  localparam int HW = $clog2(HOLD_CYCLES);
  localparam int GW = $clog2(STAGE_GAP + 1);
  localparam int CW = $clog2(N_CH + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(STAGE_GAP - 1);
  localparam logic [CW-1:0] CH_LAST   = CW'(N_CH - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  logic [N_LOCK-1:0] r_sync [SYNC_STAGES];
  logic              w_lock_s;

  state_t            r_state, w_nxt_state;
  logic [HW-1:0]     r_hold, w_nxt_hold;
  logic [GW-1:0]     r_gap, w_nxt_gap;
  logic [CW-1:0]     r_ch, w_nxt_ch;
  logic [N_CH-1:0]   r_rst_x, w_nxt_rst_x;
  logic              r_ready, w_nxt_ready;
  logic [CNT_W-1:0]  r_loss, w_nxt_loss, w_loss_inc;

  // LOCKED synchroniser chain; lock is qualified only when every bit agrees
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
    end else begin
      r_sync[0] <= i_locked;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
    end
  end

  assign w_lock_s   = &r_sync[SYNC_STAGES-1];
  assign w_loss_inc = (r_loss == {CNT_W{1'b1}}) ? r_loss : r_loss + 1'b1;

  // State, counters and registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= WAIT_LOCK;
      r_hold  <= '0;
      r_gap   <= '0;
      r_ch    <= '0;
      r_rst_x <= '0;
      r_ready <= 1'b0;
      r_loss  <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_hold  <= w_nxt_hold;
      r_gap   <= w_nxt_gap;
      r_ch    <= w_nxt_ch;
      r_rst_x <= w_nxt_rst_x;
      r_ready <= w_nxt_ready;
      r_loss  <= w_nxt_loss;
    end
  end

  // Next-state logic; lock loss is checked before the soft-reset request
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_hold  = r_hold;
    w_nxt_gap   = r_gap;
    w_nxt_ch    = r_ch;
    w_nxt_rst_x = r_rst_x;
    w_nxt_ready = r_ready;
    w_nxt_loss  = r_loss;
    case (r_state)
      WAIT_LOCK: begin
        w_nxt_rst_x = '0;
        w_nxt_ready = 1'b0;
        if (w_lock_s) begin
          w_nxt_state = HOLD;
          w_nxt_hold  = '0;
        end
      end
      HOLD: begin
        if (!w_lock_s) begin
          w_nxt_state = WAIT_LOCK;
          w_nxt_hold  = '0;
          w_nxt_gap   = '0;
          w_nxt_ch    = '0;
          w_nxt_rst_x = '0;
          w_nxt_ready = 1'b0;
        end else if (r_hold == HOLD_LAST) begin
          w_nxt_rst_x = N_CH'(1);
          w_nxt_hold  = '0;
          w_nxt_gap   = '0;
          if (N_CH == 1) begin
            w_nxt_state = RUN;
            w_nxt_ready = 1'b1;
          end else begin
            w_nxt_state = RELEASE;
            w_nxt_ch    = CW'(1);
          end
        end else begin
          w_nxt_hold = r_hold + 1'b1;
        end
      end
      RELEASE, RUN: begin
        if (!w_lock_s) begin
          w_nxt_state = WAIT_LOCK;
          w_nxt_hold  = '0;
          w_nxt_gap   = '0;
          w_nxt_ch    = '0;
          w_nxt_rst_x = '0;
          w_nxt_ready = 1'b0;
          w_nxt_loss  = w_loss_inc;
        end else if (i_srst_req) begin
          w_nxt_state = HOLD;
          w_nxt_hold  = '0;
          w_nxt_gap   = '0;
          w_nxt_ch    = '0;
          w_nxt_rst_x = '0;
          w_nxt_ready = 1'b0;
        end else if (r_state == RELEASE) begin
          if (r_gap == GAP_LAST) begin
            // channels release in order, so shifting in a one sets bit ch_idx
            w_nxt_rst_x = N_CH'({r_rst_x, 1'b1});
            w_nxt_gap   = '0;
            w_nxt_ch    = r_ch + 1'b1;
            if (r_ch == CH_LAST) begin
              w_nxt_state = RUN;
              w_nxt_ready = 1'b1;
            end
          end else begin
            w_nxt_gap = r_gap + 1'b1;
          end
        end
      end
      default: begin
        w_nxt_state = WAIT_LOCK;
        w_nxt_rst_x = '0;
        w_nxt_ready = 1'b0;
      end
    endcase
  end

  assign o_rst_x    = r_rst_x;
  assign o_ready    = r_ready;
  assign o_loss_cnt = r_loss;
  assign o_state    = r_state;

endmodule
